// File: rtl/ram_arbiter_seq.sv
// Sequencer/arbiter for the shared system block RAM: power-on/requested fill,
// then CPU-priority port sharing with a buffered, starvation-guarded loader write.
module ram_arbiter_seq #(
    parameter int unsigned         ADDR_W  = 16,
    parameter int unsigned         DATA_W  = 8,
    parameter logic [DATA_W-1:0]   FILL    = 8'hFF,
    parameter int unsigned         STARVE  = 15,
    parameter logic [ADDR_W-1:0]   LD_BASE = '0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic {S_CLEAR, S_RUN} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                pending_q;
    logic [7:0]          starve_q;
    logic                ld_ovf_q;
    logic [ADDR_W-1:0]   ld_addr_q;
    logic [DATA_W-1:0]   ld_data_q;

    logic                run;
    logic                ld_avail;
    logic                steal;
    logic                cpu_go;
    logic                ld_drain;
    logic [ADDR_W-1:0]   ld_mem_addr;

    // A clear request discards the buffered write in the same cycle, so it must not drain either.
    assign run         = (state_q == S_RUN);
    assign ld_avail    = pending_q & ~clr_req;
    assign steal       = run & ld_avail & (starve_q == STARVE[7:0]);
    assign cpu_go      = run & ~steal & cpu_cs;
    assign ld_drain    = steal | (run & ld_avail & ~cpu_cs);
    assign ld_mem_addr = ld_addr_q + LD_BASE;

    assign clr_busy = ~run;
    assign ld_ready = run & ~pending_q;
    assign ld_ovf   = ld_ovf_q;
    assign cpu_q    = mem_q;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_d     = cpu_din;
        mem_we    = 1'b0;
        cpu_stall = 1'b0;
        if (!run) begin
            mem_addr  = clr_cnt_q;
            mem_d     = FILL;
            mem_we    = 1'b1;
            cpu_stall = 1'b1;
        end else if (ld_drain) begin
            mem_addr  = ld_mem_addr;
            mem_d     = ld_data_q;
            mem_we    = 1'b1;
            cpu_stall = steal & cpu_cs;
        end else if (cpu_go) begin
            mem_we    = cpu_we;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            pending_q <= 1'b0;
            starve_q  <= '0;
            ld_ovf_q  <= 1'b0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
        end else if (clr_req) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            pending_q <= 1'b0;
            starve_q  <= '0;
            ld_ovf_q  <= 1'b0;
        end else begin
            if (ld_wr) begin
                if (ld_ready) begin
                    ld_addr_q <= ld_addr;
                    ld_data_q <= ld_data;
                    pending_q <= 1'b1;
                end else begin
                    ld_ovf_q  <= 1'b1;
                end
            end
            case (state_q)
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == '1) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Capture cannot coincide with a drain: ld_ready is low while pending.
                    if (ld_drain) begin
                        pending_q <= 1'b0;
                        starve_q  <= '0;
                    end else if (cpu_go && pending_q) begin
                        starve_q  <= starve_q + 8'd1;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter_seq.sv
// Bench for ram_arbiter_seq: RAM model on the memory port, write/read scoreboards
// fed by the stimulus and drained by a negedge monitor.
module tb_ram_arbiter_seq;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] BASE = 12'h010;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          clr_req;
    logic          clr_busy;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_q;
    logic          cpu_stall;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_ovf;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_wr[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] exp_mem [0:DEPTH-1];
    logic [DW-1:0] ram [0:DEPTH-1];
    logic mon_en = 1'b0;
    logic rd_v = 1'b0;

    ram_arbiter_seq #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .FILL   (8'hFF),
        .STARVE (15),
        .LD_BASE(BASE)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .cpu_cs   (cpu_cs),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_q    (cpu_q),
        .cpu_stall(cpu_stall),
        .ld_wr    (ld_wr),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_ovf   (ld_ovf),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_d;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (rd_v) begin
                chk("rd_avail", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) chk("cpu_q", 32'(cpu_q), 32'(rd_q.pop_front()));
            end
            rd_v = cpu_cs && !cpu_we && !cpu_stall;
            if (mem_we) begin
                chk("wr_avail", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) chk("wr", 32'({mem_addr, mem_d}), exp_wr.pop_front());
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wr.push_back(32'({a, d}));
        exp_mem[a] = d;
    endtask

    task automatic push_clear();
        for (int i = 0; i < int'(DEPTH); i++) push_wr(AW'(i), 8'hFF);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        cpu_cs = 1'b0; cpu_we = 1'b0; ld_wr = 1'b0; clr_req = 1'b0;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        rd_q.push_back(exp_mem[a]);
    endtask

    task automatic ldw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_wr = 1'b1; ld_addr = a; ld_data = d;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (1) begin
            @(negedge clk_sys);
            if (!clr_busy || n > 5000) break;
            n++;
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0; clr_req = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_din = '0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_clr_busy", 32'(clr_busy), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("rst_mem_bus", 32'({mem_we, mem_addr, mem_d}), 32'({1'b1, 12'h000, 8'hFF}));
        chk("rst_ld_ovf", 32'(ld_ovf), 32'd0);

        tick();
        reset_n = 1'b1;
        push_clear();
        mon_en = 1'b1;
        wait_clear(n);
        chk("clr_len", 32'(n), 32'(DEPTH));
        chk("run_ld_ready", 32'(ld_ready), 32'd1);

        // Idle loader write, offset by LD_BASE
        tick(); ldw(12'h234, 8'hA5); push_wr(12'h244, 8'hA5);
        @(negedge clk_sys); chk("ldw_ready_before", 32'(ld_ready), 32'd1);
        tick();
        @(negedge clk_sys); chk("ldw_ready_busy", 32'(ld_ready), 32'd0);
        chk("ldw_we", 32'(mem_we), 32'd1);
        tick();
        @(negedge clk_sys); chk("ldw_ready_after", 32'(ld_ready), 32'd1);

        // CPU write then read back
        tick(); cpu_wr(12'h100, 8'h3C); push_wr(12'h100, 8'h3C);
        @(negedge clk_sys); chk("cpuw_stall", 32'(cpu_stall), 32'd0);
        tick(); cpu_rd(12'h100);
        @(negedge clk_sys); chk("cpur_stall", 32'(cpu_stall), 32'd0);
        tick();
        @(negedge clk_sys);

        // Starvation: CPU holds the port, loader write pending
        tick(); cpu_wr(12'h300, 8'h11); ldw(12'h050, 8'h77); push_wr(12'h300, 8'h11);
        @(negedge clk_sys); chk("stv_cap_stall", 32'(cpu_stall), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            tick(); cpu_wr(12'h300, 8'h11); push_wr(12'h300, 8'h11);
            @(negedge clk_sys); chk("stv_cpu_stall", 32'(cpu_stall), 32'd0);
        end
        tick(); cpu_wr(12'h300, 8'h11); push_wr(12'h060, 8'h77);
        @(negedge clk_sys); chk("stv_steal_stall", 32'(cpu_stall), 32'd1);
        tick(); cpu_wr(12'h300, 8'h11); push_wr(12'h300, 8'h11);
        @(negedge clk_sys); chk("stv_after_stall", 32'(cpu_stall), 32'd0);
        chk("stv_after_ready", 32'(ld_ready), 32'd1);

        // Overflow, then clr_req with a pending write that must be discarded
        tick(); cpu_wr(12'h301, 8'h22); ldw(12'h400, 8'h88); push_wr(12'h301, 8'h22);
        @(negedge clk_sys);
        tick(); cpu_wr(12'h301, 8'h22); ldw(12'h401, 8'h99); push_wr(12'h301, 8'h22);
        @(negedge clk_sys); chk("ovf_ready", 32'(ld_ready), 32'd0);
        chk("ovf_pre", 32'(ld_ovf), 32'd0);
        tick(); cpu_wr(12'h301, 8'h22); push_wr(12'h301, 8'h22);
        @(negedge clk_sys); chk("ovf_set", 32'(ld_ovf), 32'd1);
        tick(); clr_req = 1'b1;
        @(negedge clk_sys); chk("clrreq_we", 32'(mem_we), 32'd0);
        chk("clrreq_ovf_hold", 32'(ld_ovf), 32'd1);
        tick(); ldw(12'h500, 8'h55);
        push_clear();
        @(negedge clk_sys); chk("clr2_ovf_clr", 32'(ld_ovf), 32'd0);
        chk("clr2_busy", 32'(clr_busy), 32'd1);
        tick();
        @(negedge clk_sys); chk("clr2_drop_ovf", 32'(ld_ovf), 32'd1);
        tick();
        wait_clear(n);
        chk("clr2_len", 32'(n), 32'(DEPTH - 2));

        // Clear wiped earlier data; loader address wraps modulo depth
        tick(); cpu_rd(12'h300);
        @(negedge clk_sys);
        tick(); ldw(12'hFF8, 8'hC3); push_wr(12'h008, 8'hC3);
        @(negedge clk_sys);
        tick();
        @(negedge clk_sys); chk("wrap_addr", 32'(mem_addr), 32'h008);
        tick(); cpu_rd(12'h008);
        @(negedge clk_sys);
        tick(); cpu_rd(12'h100);
        @(negedge clk_sys);

        // Held clr_req rewrites location 0 until release
        tick(); clr_req = 1'b1;
        @(negedge clk_sys); chk("hold_run", 32'(clr_busy), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick(); clr_req = 1'b1; push_wr(12'h000, 8'hFF);
            @(negedge clk_sys); chk("hold_addr0", 32'({clr_busy, mem_addr}), 32'({1'b1, 12'h000}));
        end
        tick();
        push_clear();
        wait_clear(n);
        chk("clr3_len", 32'(n), 32'(DEPTH));
        chk("clr3_ovf", 32'(ld_ovf), 32'd0);

        tick();
        @(negedge clk_sys);
        tick();
        @(negedge clk_sys);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        chk("rd_left", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
